// File: rtl/register_file_sb.sv
// Multi-read, dual-write register file with per-register busy scoreboard for decode stall.
// Reads are combinational (optional same-cycle forwarding); writes, issue and flush act on the rising edge.
module register_file_sb #(
    parameter int BIT_WIDTH       = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0,
    parameter int REG_INDEX_WIDTH = 4,
    parameter int NUM_READ        = 2,
    parameter int BYPASS          = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_READ*REG_INDEX_WIDTH-1:0] rd_ind,
    input  logic [NUM_READ-1:0]                 rd_used,
    output logic [NUM_READ*BIT_WIDTH-1:0]       rd_data,
    output logic [NUM_READ-1:0]                 rd_busy,
    output logic                                stall,
    input  logic                                en_write0,
    input  logic [REG_INDEX_WIDTH-1:0]          dr_ind0,
    input  logic [BIT_WIDTH-1:0]                data_in0,
    input  logic                                en_write1,
    input  logic [REG_INDEX_WIDTH-1:0]          dr_ind1,
    input  logic [BIT_WIDTH-1:0]                data_in1,
    input  logic                                issue_en,
    input  logic [REG_INDEX_WIDTH-1:0]          issue_ind,
    input  logic                                flush
);
    localparam int DEPTH = 2 ** REG_INDEX_WIDTH;
    localparam bit BYP   = (BYPASS != 0);

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     busy_nxt;

    // Lowest priority applied first so later statements override: write clear < issue set < flush.
    always_comb begin
        busy_nxt = busy;
        if (en_write0) busy_nxt[dr_ind0] = 1'b0;
        if (en_write1) busy_nxt[dr_ind1] = 1'b0;
        if (issue_en)  busy_nxt[issue_ind] = 1'b1;
        if (flush)     busy_nxt = '0;
    end

    // Port 1 is written first so port 0 overrides on an index collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
            busy <= '0;
        end else begin
            if (en_write1) mem[dr_ind1] <= data_in1;
            if (en_write0) mem[dr_ind0] <= data_in0;
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [REG_INDEX_WIDTH-1:0] ind;
        logic                       hit0;
        logic                       hit1;

        assign ind  = rd_ind[k*REG_INDEX_WIDTH +: REG_INDEX_WIDTH];
        // Forwarding is suppressed in reset so reads show the cleared array.
        assign hit0 = BYP && !reset && en_write0 && (dr_ind0 == ind);
        assign hit1 = BYP && !reset && en_write1 && (dr_ind1 == ind);

        assign rd_data[k*BIT_WIDTH +: BIT_WIDTH] = hit0 ? data_in0 :
                                                  hit1 ? data_in1 : mem[ind];
        assign rd_busy[k] = busy[ind] && !(hit0 || hit1);
    end

    assign stall = |(rd_busy & rd_used);
endmodule
